// File: rtl/dmem_responder.sv
// Word-addressed 16-bit data-memory responder with fixed wait states and pipeline stall.
// Optional DMEM_ERR_EN: adds err port and flags accesses with nonzero address bits above AW.
module dmem_responder #(
    parameter int AW   = 8,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ren,
    input  logic        req_wen,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] acc_cnt
`ifdef DMEM_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q;
    logic [15:0] addr_q, wdata_q;
    logic        capture;

    logic [15:0] mem [0:(1<<AW)-1];

    // With WAIT==0 the RESP entry edge is also the capture edge, so the
    // access operands come straight from the request port in that case.
    logic        acc_wen;
    logic [15:0] acc_addr, acc_wdata;
    logic        enter_resp;
    logic        oor;

    assign acc_wen    = (state_q == S_IDLE) ? req_wen   : wen_q;
    assign acc_addr   = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign enter_resp = (state_d == S_RESP);

`ifdef DMEM_ERR_EN
    assign oor = |acc_addr[15:AW];
`else
    logic unused_hi;
    assign oor       = 1'b0;
    assign unused_hi = ^acc_addr[15:AW];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ren || req_wen) begin
                    stall   = 1'b1;
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!rst) stall = 1'b0;
    end

    assign rsp_valid = (state_q == S_RESP);

    logic err_q;
`ifdef DMEM_ERR_EN
    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wen_q     <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rsp_rdata <= 16'h0000;
            acc_cnt   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                wen_q   <= req_wen;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            err_q <= enter_resp && oor;
            if (enter_resp) begin
                rsp_rdata <= oor ? 16'h0000 : mem[acc_addr[AW-1:0]];
                acc_cnt   <= acc_cnt + 16'd1;
            end
        end
    end

    // RAM has no reset; a write only lands on a non-reset RESP entry edge.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && acc_wen && !oor)
            mem[acc_addr[AW-1:0]] <= acc_wdata;
    end

endmodule
